// File: rtl/fp_addsub_pipe_if.sv
// Operand/result handshake bundle for the pipelined IEEE-754 add/subtract unit.
interface fp_addsub_pipe_if #(
    parameter int EXP = 8,
    parameter int MAN = 23
);
    localparam int W = EXP + MAN + 1;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (output in_valid, a, b, op, out_ready,
                    input  in_ready, out_valid, result, flags);
    modport slave  (input  in_valid, a, b, op, out_ready,
                    output in_ready, out_valid, result, flags);
endinterface

// File: rtl/fp_addsub_pipe.sv
// Four-stage IEEE-754 add/subtract: unpack/swap, align/add, normalise, round/pack.
// Round-to-nearest-even, subnormal inputs flushed to zero, whole pipe holds on output backpressure.
module fp_addsub_pipe #(
    parameter int EXP = 8,
    parameter int MAN = 23
) (
    input  logic            clk,
    input  logic            rst,
    fp_addsub_pipe_if.slave bus
);
    localparam int W      = EXP + MAN + 1;
    localparam int EW     = EXP + 2;      // signed working exponent
    localparam int XW     = MAN + 4;      // {hidden, frac, G, R, S}
    localparam int STAGES = 4;
    localparam logic [EXP-1:0]       EMAX = '1;
    localparam logic [W-1:0]         QNAN = {1'b0, EMAX, 1'b1, {(MAN-1){1'b0}}};
    localparam logic signed [EW-1:0] EONE = 1;
    localparam logic signed [EW-1:0] EOVF = EW'((1 << EXP) - 1);

    typedef struct packed {
        logic         spec;
        logic [W-1:0] res;
        logic [3:0]   flg;
    } spec_t;

    typedef struct packed {
        spec_t          sp;
        logic           sign;
        logic           sub;
        logic [EXP-1:0] eb;
        logic [EXP-1:0] es;
        logic [MAN:0]   mb;
        logic [MAN:0]   ms;
    } s1_t;

    typedef struct packed {
        spec_t          sp;
        logic           sign;
        logic [EXP-1:0] exp;
        logic [XW:0]    sum;
    } s2_t;

    typedef struct packed {
        spec_t          sp;
        logic           sign;
        logic           zero;
        logic [EW-1:0]  exp;
        logic [XW-1:0]  man;
    } s3_t;

    logic [STAGES:1] vld_pipe;
    logic            rdy_en;
    logic            stall;
    logic            accept;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q;
    s3_t             s3_d, s3_q;
    logic [W-1:0]    res_d, res_q;
    logic [3:0]      flg_d, flg_q;

    assign stall         = vld_pipe[STAGES] & ~bus.out_ready;
    assign bus.in_ready  = rdy_en & ~stall;
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.result    = res_q;
    assign bus.flags     = flg_q;

    function automatic logic [EW-1:0] lzc(input logic [XW-1:0] v);
        lzc = EW'(XW);
        for (int i = 0; i < XW; i++)
            if (v[i]) lzc = EW'(XW - 1 - i);
    endfunction

    // S1: unpack, classify, flush subnormals, order by magnitude
    logic           sa, sb, za, zb, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;
    logic [EXP-1:0] ea, eb;
    logic [MAN-1:0] fa, fb;

    always_comb begin
        sa     = bus.a[W-1];
        sb     = bus.b[W-1] ^ bus.op;
        ea     = bus.a[W-2:MAN];
        eb     = bus.b[W-2:MAN];
        za     = (ea == '0);
        zb     = (eb == '0);
        inf_a  = (ea == EMAX) && (bus.a[MAN-1:0] == '0);
        inf_b  = (eb == EMAX) && (bus.b[MAN-1:0] == '0);
        nan_a  = (ea == EMAX) && (bus.a[MAN-1:0] != '0);
        nan_b  = (eb == EMAX) && (bus.b[MAN-1:0] != '0);
        snan_a = nan_a & ~bus.a[MAN-1];
        snan_b = nan_b & ~bus.b[MAN-1];
        fa     = za ? '0 : bus.a[MAN-1:0];
        fb     = zb ? '0 : bus.b[MAN-1:0];

        s1_d     = '0;
        s1_d.sub = sa ^ sb;
        if ({ea, fa} >= {eb, fb}) begin
            s1_d.sign = sa;
            s1_d.eb   = ea;  s1_d.mb = {~za, fa};
            s1_d.es   = eb;  s1_d.ms = {~zb, fb};
        end else begin
            s1_d.sign = sb;
            s1_d.eb   = eb;  s1_d.mb = {~zb, fb};
            s1_d.es   = ea;  s1_d.ms = {~za, fa};
        end

        if (nan_a | nan_b)
            s1_d.sp = '{1'b1, QNAN, {snan_a | snan_b, 3'b000}};
        else if (inf_a & inf_b & (sa ^ sb))
            s1_d.sp = '{1'b1, QNAN, 4'b1000};
        else if (inf_a)
            s1_d.sp = '{1'b1, {sa, EMAX, {MAN{1'b0}}}, 4'b0000};
        else if (inf_b)
            s1_d.sp = '{1'b1, {sb, EMAX, {MAN{1'b0}}}, 4'b0000};
        else if (za & zb)
            s1_d.sp = '{1'b1, {sa & sb, {(W-1){1'b0}}}, 4'b0000};
    end

    // S2: align the smaller operand; everything shifted past S folds into S
    logic [EXP-1:0]   diff, shamt;
    logic [2*XW-1:0]  wide;
    logic [XW-1:0]    sm;
    logic [XW:0]      big;

    always_comb begin
        diff  = s1_q.eb - s1_q.es;
        shamt = (diff > EXP'(MAN + 3)) ? EXP'(MAN + 3) : diff;
        wide  = {s1_q.ms, 3'b000, {XW{1'b0}}} >> shamt;
        sm    = {wide[2*XW-1:XW+1], wide[XW] | (|wide[XW-1:0])};
        big   = {1'b0, s1_q.mb, 3'b000};

        s2_d      = '0;
        s2_d.sp   = s1_q.sp;
        s2_d.sign = s1_q.sign;
        s2_d.exp  = s1_q.eb;
        s2_d.sum  = s1_q.sub ? big - {1'b0, sm} : big + {1'b0, sm};
    end

    // S3: normalise to a leading one at bit XW-1
    logic [EW-1:0] lz, exp_in;

    always_comb begin
        lz     = lzc(s2_q.sum[XW-1:0]);
        exp_in = {2'b00, s2_q.exp};

        s3_d      = '0;
        s3_d.sp   = s2_q.sp;
        s3_d.sign = s2_q.sign;
        s3_d.zero = (s2_q.sum == '0);
        if (s2_q.sum[XW]) begin
            s3_d.man = {s2_q.sum[XW:2], s2_q.sum[1] | s2_q.sum[0]};
            s3_d.exp = exp_in + EW'(1);
        end else begin
            s3_d.man = s2_q.sum[XW-1:0] << lz;
            s3_d.exp = exp_in - lz;
        end
    end

    // S4: round to nearest even, then pack or saturate
    logic                 g, r, st, rup;
    logic [MAN+1:0]       mr;
    logic [MAN-1:0]       frac;
    logic signed [EW-1:0] e3, exp_r;

    always_comb begin
        g     = s3_q.man[2];
        r     = s3_q.man[1];
        st    = s3_q.man[0];
        rup   = g & (r | st | s3_q.man[3]);
        mr    = {1'b0, s3_q.man[XW-1:3]} + (MAN+2)'(rup);
        // a rounding carry leaves mr = 10..0, so the shifted view is the zero fraction
        frac  = mr[MAN+1] ? mr[MAN:1] : mr[MAN-1:0];
        e3    = $signed(s3_q.exp);
        exp_r = $signed(s3_q.exp + EW'(mr[MAN+1]));

        if (s3_q.sp.spec) begin
            res_d = s3_q.sp.res;
            flg_d = s3_q.sp.flg;
        end else if (s3_q.zero) begin
            res_d = '0;
            flg_d = 4'b0000;
        end else if (e3 < EONE) begin
            res_d = {s3_q.sign, {(W-1){1'b0}}};
            flg_d = 4'b0011;
        end else if (exp_r >= EOVF) begin
            res_d = {s3_q.sign, EMAX, {MAN{1'b0}}};
            flg_d = 4'b0101;
        end else begin
            res_d = {s3_q.sign, exp_r[EXP-1:0], frac};
            flg_d = {3'b000, g | r | st};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            rdy_en   <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            res_q    <= '0;
            flg_q    <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (!stall) begin
                vld_pipe <= {vld_pipe[STAGES-1:1], accept};
                s1_q     <= s1_d;
                s2_q     <= s2_d;
                s3_q     <= s3_d;
                res_q    <= res_d;
                flg_q    <= flg_d;
            end
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed-vector bench for fp_addsub_pipe (single precision) with a queue scoreboard.
module tb_fp_addsub_pipe;
    localparam int EXP = 8;
    localparam int MAN = 23;
    localparam int W   = EXP + MAN + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_ret = 0;

    fp_addsub_pipe_if #(.EXP(EXP), .MAN(MAN)) bus ();
    fp_addsub_pipe #(.EXP(EXP), .MAN(MAN)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flg;
        int           acc;
        bit           lat;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
        logic [W-1:0] res;
        logic [3:0]   flg;
    } vec_t;

    exp_t sb[$];
    exp_t cur;

    vec_t vecs [16] = '{
        '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000},  // 1 + 2
        '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000},  // exact cancel -> +0
        '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000},  // -0 + -0
        '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001},  // tie, even stays
        '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001},  // tie, odd rounds up
        '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101},  // overflow
        '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000},  // inf - inf
        '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000},  // sNaN
        '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000},  // qNaN, quiet
        '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000},  // -inf + finite
        '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000},  // 1 - 2 = -1
        '{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0000},  // carry path
        '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000},  // subnormal flushed
        '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011},  // underflow
        '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001},  // far small -> sticky
        '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000}   // +0 + -0
    };

    logic [W-1:0] a5 [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [W-1:0] r5 [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                             32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Present one operation and hold it until accepted; ends on the negedge after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                         input logic [W-1:0] res, input logic [3:0] flg, input bit lat);
        int n = 0;
        bus.a = a; bus.b = b; bus.op = op; bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!bus.in_ready) check("accept timeout", 32'(bus.in_ready), 32'd1);
        else sb.push_back('{res, flg, cyc, lat});
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk); n++;
        end
        check("drain pending", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: retire happens on the next posedge when out_valid & out_ready
    always @(negedge clk) begin
        #2;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected result", 32'(bus.out_valid), 32'd0);
            end else begin
                cur = sb.pop_front();
                n_ret++;
                check("result", bus.result, cur.res);
                check("flags", 32'(bus.flags), 32'(cur.flg));
                if (cur.lat) check("latency", 32'(cyc - cur.acc), 32'd4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, %0d results pending", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = 1'b0; bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset flags", 32'(bus.flags), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1 check("in_ready right after release", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("in_ready one cycle after release", 32'(bus.in_ready), 32'd1);

        // Directed vectors, back to back at full rate
        foreach (vecs[i])
            issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flg, 1'b1);
        idle(1);
        drain();

        // Backpressure: 8 ops, consumer stalls for 4 cycles once results start
        idle(2);
        r0 = n_ret;
        fork
            begin
                for (int i = 0; i < 8; i++) issue(a5[i], 32'h3F800000, 1'b0, r5[i], 4'b0000, 1'b0);
            end
            begin
                repeat (4) @(negedge clk);
                for (int k = 0; k < 4; k++) begin
                    bus.out_ready = 1'b0;
                    #1 check("in_ready under stall", 32'(bus.in_ready), 32'd0);
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
        join
        idle(1);
        drain();
        check("retired count", 32'(n_ret - r0), 32'd8);

        // Reset with operations in flight discards them
        idle(2);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue(a5[i], 32'h3F800000, 1'b0, r5[i], 4'b0000, 1'b0);
        idle(1);
        check("held output before reset", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        sb.delete();
        #1;
        check("out_valid on reset", 32'(bus.out_valid), 32'd0);
        check("in_ready on reset", 32'(bus.in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        idle(8);
        issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 1'b1);
        idle(1);
        drain();
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
